sram_cmd_frontend: RTL and testbench
====================================

Name: sram_cmd_frontend

Overview:
- Conditions the board's raw user inputs (two push-buttons plus address/data switches) into clean, timed command strobes for the SRAM interface stage downstream.
- Outputs map one-to-one onto that stage's inputs: chip_enable, write_enable, output_enable, data_in, address.
- Synchronises, debounces and edge-detects the keys.
- Latches a stable address/data snapshot per command and holds strobes long enough for one complete interface cycle.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
- CNT_W, 19, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
- HOLD_CYCLES, 4, cycles the active strobes stay low per command (≥3 so the downstream write completes).
- GAP_CYCLES, 2, cycles with all strobes high after a command, before the next one is accepted.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- key_write_n  in  1  raw push-button, active low, asynchronous, bouncy
- key_read_n  in  1  raw push-button, active low, asynchronous, bouncy
- sw_data  in  4  raw data switches, asynchronous
- sw_address  in  4  raw address switches, asynchronous
- chip_enable  out  1  active-low strobe to interface
- write_enable  out  1  active-low strobe to interface
- output_enable  out  1  active-low strobe to interface
- data_in  out  4  latched write data
- address  out  4  latched address
- busy  out  1  high while a command is in flight (hold + gap)
- dropped  out  1  one-cycle pulse when a press is discarded
- cmd_count  out  8  commands issued, wraps 255->0

Behaviour:
- Single clock. Reset is synchronous, active-low (reset_n sampled on rising clock edge); one clock domain only.
- Reset values: strobes=1, data_in=0, address=0, busy=0, dropped=0, cmd_count=0. Sync flops=1, debounced levels=1 (released), debounce counters=0, switch sync=0, FSM=IDLE.
- Reset mid-command: all strobes return high on the reset edge; no partial command resumes.
- Synchronisation: keys and switches each pass two flops before use.
- Debounce, per key:
  - Counter increments each cycle synced != debounced; clears when they are equal.
  - When counter==DEBOUNCE_CYCLES-1 and still differing: debounced<=synced and counter<=0.
  - On a 1->0 flip, a registered press pulse is high for exactly one cycle.
- Latency: first raw-low sampling edge = edge 1; debounced flips and press pulse registered at edge DEBOUNCE_CYCLES+2; strobes low at edge DEBOUNCE_CYCLES+3.
- Key held through reset release: counts as a new press after debounce.
- Key release: produces no command.
- FSM states:
  - IDLE: busy=0.
    - press_w: latch synced switches into data_in/address, chip_enable=0, write_enable=0, output_enable=1, ->WRITE.
    - press_r (and no press_w): latch address, chip_enable=0, output_enable=0, write_enable=1, ->READ. data_in keeps its prior value.
  - WRITE / READ: strobes held constant for exactly HOLD_CYCLES cycles, then all strobes=1, ->GAP.
  - GAP: strobes high for exactly GAP_CYCLES cycles, then ->IDLE. busy=0 in the first IDLE cycle.
  - Unused encodings: ->IDLE with strobes high.
- busy=1 from the strobe-assert edge until GAP ends.
- cmd_count increments on the edge that enters WRITE or READ.
- Simultaneous press_w and press_r in IDLE: write wins; read is dropped (dropped pulse).
- Any press while not IDLE: discarded, dropped=1 for one cycle, no queueing.
- data_in/address stay stable for the entire command regardless of switch activity.

Decomposition:
- Package sram_fe_pkg: FSM state encoding (IDLE, WRITE, READ, GAP) and default constants for DEBOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES.
- One sub-module key_debouncer (2-flop sync + counter + debounced level + press pulse), instantiated once per key.
- Switch synchronisers, hold/gap counter and FSM stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=4, GAP_CYCLES=2):
- Write: sw_data=4'hA, sw_address=4'h3, key_write_n low for 10 cycles. Response:
  - chip_enable=write_enable=0 at edge 7 for exactly 4 cycles, output_enable=1.
  - data_in=A, address=3 throughout; busy high 6 cycles; cmd_count=1.
- Read: sw_address=4'h5, key_read_n low. Response: chip_enable=output_enable=0 for 4 cycles, write_enable=1, address=5, cmd_count increments.
- Bounce: key_write_n toggled every 2 cycles for 20 cycles, then released. Response: no strobe activity, cmd_count unchanged.
- Both keys pressed on the same cycle. Response: only a write is issued; dropped pulses once; cmd_count +1.
- Second press during busy. Response: dropped pulses; no second command; IDLE reached after the gap.
- reset_n low during WRITE hold. Response: strobes=1, busy=0, cmd_count=0, data_in=address=0 on the next edge. With keys released, no strobe activity follows.

Source files
------------

// File: rtl/sram_fe_pkg.sv
// Shared types and default timing constants for the SRAM command front-end.
// The FSM encoding fills all four 2-bit codes; the top still decodes defensively.
package sram_fe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 19;
  localparam int HOLD_CYCLES_DEF     = 4;
  localparam int GAP_CYCLES_DEF      = 2;

  // Width able to hold 0..max(hold,gap)-1 for the phase timer.
  function automatic int tmr_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser, stability counter and debounced level for one
// active-low key; emits a one-cycle press pulse on each accepted 1->0 change.
module key_debouncer
  import sram_fe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // NOTE: sequential state uses non-blocking assignments and a reset sampled
  // on the clock edge, so every flop here updates from pre-edge values only.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/sram_cmd_frontend.sv
// Turns raw keys and switches into timed chip/write/output-enable strobes with
// a latched address/data snapshot, one command at a time.
module sram_cmd_frontend
  import sram_fe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int GAP_CYCLES      = GAP_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_write_n,
  input  logic       key_read_n,
  input  logic [3:0] sw_data,
  input  logic [3:0] sw_address,
  output logic       chip_enable,
  output logic       write_enable,
  output logic       output_enable,
  output logic [3:0] data_in,
  output logic [3:0] address,
  output logic       busy,
  output logic       dropped,
  output logic [7:0] cmd_count
);

  localparam int TMR_W = tmr_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  logic w_press_w;
  logic w_press_r;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_write (
    .clock  (clock),
    .reset_n(reset_n),
    .i_key_n(key_write_n),
    .o_press(w_press_w)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_read (
    .clock  (clock),
    .reset_n(reset_n),
    .i_key_n(key_read_n),
    .o_press(w_press_r)
  );

  logic [3:0] r_sw_data_s1, r_sw_data_s2;
  logic [3:0] r_sw_addr_s1, r_sw_addr_s2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sw_data_s1 <= '0;
      r_sw_data_s2 <= '0;
      r_sw_addr_s1 <= '0;
      r_sw_addr_s2 <= '0;
    end else begin
      r_sw_data_s1 <= sw_data;
      r_sw_data_s2 <= r_sw_data_s1;
      r_sw_addr_s1 <= sw_address;
      r_sw_addr_s2 <= r_sw_addr_s1;
    end
  end

  state_e           r_state;
  state_e           w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic             w_hold_done;
  logic             w_gap_done;
  logic             w_accept;

  assign w_hold_done = (r_timer == HOLD_LAST);
  assign w_gap_done  = (r_timer == GAP_LAST);
  assign w_accept    = (r_state == ST_IDLE) && (w_press_w || w_press_r);

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_press_w)      w_state_next = ST_WRITE;
        else if (w_press_r) w_state_next = ST_READ;
      end
      ST_WRITE, ST_READ: if (w_hold_done) w_state_next = ST_GAP;
      ST_GAP:            if (w_gap_done)  w_state_next = ST_IDLE;
      default:           w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the next state and are registered, so the strobes reach
  // the SRAM pins straight from flops without decode glitches.
  logic w_ce_next, w_we_next, w_oe_next, w_busy_next;

  always_comb begin
    w_ce_next   = 1'b1;
    w_we_next   = 1'b1;
    w_oe_next   = 1'b1;
    w_busy_next = 1'b0;
    case (w_state_next)
      ST_WRITE: begin
        w_ce_next   = 1'b0;
        w_we_next   = 1'b0;
        w_busy_next = 1'b1;
      end
      ST_READ: begin
        w_ce_next   = 1'b0;
        w_oe_next   = 1'b0;
        w_busy_next = 1'b1;
      end
      ST_GAP:  w_busy_next = 1'b1;
      default: w_busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                     r_timer <= '0;
    else if (r_state != w_state_next) r_timer <= '0;
    else if (r_state != ST_IDLE)      r_timer <= r_timer + 1'b1;
  end

  logic       r_chip_enable, r_write_enable, r_output_enable, r_busy, r_dropped;
  logic [3:0] r_data_in, r_address;
  logic [7:0] r_cmd_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_chip_enable   <= 1'b1;
      r_write_enable  <= 1'b1;
      r_output_enable <= 1'b1;
      r_busy          <= 1'b0;
      r_dropped       <= 1'b0;
      r_data_in       <= '0;
      r_address       <= '0;
      r_cmd_count     <= '0;
    end else begin
      r_chip_enable   <= w_ce_next;
      r_write_enable  <= w_we_next;
      r_output_enable <= w_oe_next;
      r_busy          <= w_busy_next;
      // In IDLE only a read losing to a simultaneous write is discarded.
      r_dropped <= (r_state == ST_IDLE) ? (w_press_w && w_press_r)
                                        : (w_press_w || w_press_r);
      if (w_accept) begin
        r_address   <= r_sw_addr_s2;
        r_cmd_count <= r_cmd_count + 8'd1;
        if (w_press_w) r_data_in <= r_sw_data_s2;
      end
    end
  end

  assign chip_enable   = r_chip_enable;
  assign write_enable  = r_write_enable;
  assign output_enable = r_output_enable;
  assign busy          = r_busy;
  assign dropped       = r_dropped;
  assign data_in       = r_data_in;
  assign address       = r_address;
  assign cmd_count     = r_cmd_count;

endmodule

// File: tb/tb_sram_cmd_frontend.sv
// Scoreboard bench: stimulus queues expected commands, a negedge monitor pops
// and checks each strobe burst (latency, levels, hold/gap length, stability).
module tb_sram_cmd_frontend;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       key_write_n;
  logic       key_read_n;
  logic [3:0] sw_data;
  logic [3:0] sw_address;
  logic       chip_enable, write_enable, output_enable, busy, dropped;
  logic [3:0] data_in, address;
  logic [7:0] cmd_count;

  sram_cmd_frontend #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_write_n  (key_write_n),
    .key_read_n   (key_read_n),
    .sw_data      (sw_data),
    .sw_address   (sw_address),
    .chip_enable  (chip_enable),
    .write_enable (write_enable),
    .output_enable(output_enable),
    .data_in      (data_in),
    .address      (address),
    .busy         (busy),
    .dropped      (dropped),
    .cmd_count    (cmd_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_wr;
    logic [3:0] data;
    logic [3:0] addr;
    logic [7:0] count;
    int         start;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   phase = 0;
  int   hold_len = 0;
  int   gap_len = 0;
  int   drop_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) if (reset_n === 1'b1 && dropped === 1'b1) drop_seen++;

  // Monitor: one expected entry per strobe burst.
  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      phase = 0;
    end else begin
      case (phase)
        0: if (chip_enable === 1'b0) begin
          check("cmd_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("latency_cycle", 32'(cyc), 32'(cur.start));
            check("start_we", 32'(write_enable), cur.is_wr ? 0 : 1);
            check("start_oe", 32'(output_enable), cur.is_wr ? 1 : 0);
            check("start_data", 32'(data_in), 32'(cur.data));
            check("start_addr", 32'(address), 32'(cur.addr));
            check("start_count", 32'(cmd_count), 32'(cur.count));
            check("start_busy", 32'(busy), 1);
          end
          hold_len = 1;
          phase = 1;
        end
        1: if (chip_enable === 1'b0) begin
          hold_len++;
          check("hold_strobes", 32'({write_enable, output_enable}), cur.is_wr ? 32'b01 : 32'b10);
          check("hold_data", 32'(data_in), 32'(cur.data));
          check("hold_addr", 32'(address), 32'(cur.addr));
        end else begin
          check("hold_len", 32'(hold_len), HOLD);
          check("gap_strobes", 32'({chip_enable, write_enable, output_enable}), 32'b111);
          check("gap_busy", 32'(busy), 1);
          gap_len = 1;
          phase = 2;
        end
        default: if (busy === 1'b1) begin
          gap_len++;
          check("gap_strobes", 32'({chip_enable, write_enable, output_enable}), 32'b111);
        end else begin
          check("gap_len", 32'(gap_len), GAP);
          phase = 0;
        end
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input bit is_wr, input logic [3:0] d, input logic [3:0] a,
                          input logic [7:0] c);
    cmd_t e;
    e.is_wr = is_wr;
    e.data  = d;
    e.addr  = a;
    e.count = c;
    e.start = cyc + 7;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(1);
      if (exp_q.size() == 0 && phase == 0 && busy === 1'b0) done = 1'b1;
    end
    check("wait_done", 32'(done), 1);
  endtask

  initial begin
    int d0;
    reset_n     = 1'b0;
    key_write_n = 1'b1;
    key_read_n  = 1'b1;
    sw_data     = 4'h0;
    sw_address  = 4'h0;
    step(3);
    reset_n = 1'b1;
    check("rst_strobes", 32'({chip_enable, write_enable, output_enable}), 32'b111);
    check("rst_data", 32'(data_in), 0);
    check("rst_addr", 32'(address), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dropped", 32'(dropped), 0);
    check("rst_count", 32'(cmd_count), 0);

    // Write A to 3; switches move mid-hold and must not disturb the snapshot.
    sw_data = 4'hA;
    sw_address = 4'h3;
    step(3);
    push_cmd(1'b1, 4'hA, 4'h3, 8'd1);
    key_write_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 8) begin
        sw_data = 4'h5;
        sw_address = 4'hC;
      end
    end
    key_write_n = 1'b1;
    wait_done();
    step(10);
    check("wr_count", 32'(cmd_count), 1);
    check("wr_data_kept", 32'(data_in), 32'hA);

    // Read from 5; data_in keeps the previous write data.
    sw_address = 4'h5;
    sw_data = 4'hF;
    step(3);
    push_cmd(1'b0, 4'hA, 4'h5, 8'd2);
    key_read_n = 1'b0;
    step(10);
    key_read_n = 1'b1;
    wait_done();
    step(10);
    check("rd_count", 32'(cmd_count), 2);

    // Bouncing key never stays low long enough.
    d0 = drop_seen;
    for (int i = 0; i < 10; i++) begin
      key_write_n = (i % 2 == 1);
      step(2);
    end
    key_write_n = 1'b1;
    step(20);
    check("bounce_count", 32'(cmd_count), 2);
    check("bounce_drops", 32'(drop_seen - d0), 0);

    // Both keys together: write wins, read dropped once.
    sw_data = 4'h6;
    sw_address = 4'h9;
    step(3);
    d0 = drop_seen;
    push_cmd(1'b1, 4'h6, 4'h9, 8'd3);
    key_write_n = 1'b0;
    key_read_n  = 1'b0;
    step(10);
    key_write_n = 1'b1;
    key_read_n  = 1'b1;
    wait_done();
    step(10);
    check("both_drops", 32'(drop_seen - d0), 1);
    check("both_count", 32'(cmd_count), 3);

    // Read press landing during the write hold is discarded.
    sw_data = 4'h1;
    sw_address = 4'h2;
    step(3);
    d0 = drop_seen;
    push_cmd(1'b1, 4'h1, 4'h2, 8'd4);
    key_write_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 3) key_read_n = 1'b0;
    end
    key_write_n = 1'b1;
    key_read_n  = 1'b1;
    wait_done();
    step(10);
    check("busy_drops", 32'(drop_seen - d0), 1);
    check("busy_count", 32'(cmd_count), 4);

    // Reset in the middle of a write hold.
    sw_data = 4'h7;
    sw_address = 4'h8;
    step(3);
    push_cmd(1'b1, 4'h7, 4'h8, 8'd5);
    key_write_n = 1'b0;
    step(7);
    key_write_n = 1'b1;
    step(1);
    check("pre_rst_ce", 32'(chip_enable), 0);
    reset_n = 1'b0;
    step(1);
    check("midrst_strobes", 32'({chip_enable, write_enable, output_enable}), 32'b111);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_count", 32'(cmd_count), 0);
    check("midrst_data", 32'(data_in), 0);
    check("midrst_addr", 32'(address), 0);
    reset_n = 1'b1;
    step(30);
    check("post_rst_count", 32'(cmd_count), 0);
    check("post_rst_busy", 32'(busy), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
